// File: rtl/mode_sequencer_if.sv
// Signal bundle between the mode button/strobe source and the mode sequencer.
// There is no valid/ready handshake: button is a raw level, sample_strobe is a one-cycle
// pulse, and every output is a registered level except mode_change, a one-cycle pulse.
interface mode_sequencer_if;
  logic       button;
  logic       sample_strobe;
  logic [1:0] mode;
  logic       mute;
  logic       mode_change;
  logic       busy;
  logic [1:0] dbg_state;

  modport master (
    output button, sample_strobe,
    input  mode, mute, mode_change, busy, dbg_state
  );

  modport slave (
    input  button, sample_strobe,
    output mode, mute, mode_change, busy, dbg_state
  );
endinterface

// File: rtl/mode_sequencer.sv
// Debounces the front-panel mode key and advances the 2-bit mode register once per press,
// only inside a muted window aligned to audio sample strobes.
module mode_sequencer #(
  parameter int DEBOUNCE_CYCLES = 1000,
  parameter int MUTE_SAMPLES    = 4
) (
  input logic             clk,
  input logic             n_rst,
  mode_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FADE_OUT = 2'd1,
    SWITCH   = 2'd2,
    FADE_IN  = 2'd3
  } state_t;

  localparam int DW = $clog2(DEBOUNCE_CYCLES);
  localparam int SW = (MUTE_SAMPLES > 1) ? $clog2(MUTE_SAMPLES) : 1;
  localparam logic [DW-1:0] DB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [SW-1:0] SMP_LAST = SW'(MUTE_SAMPLES - 1);

  logic [1:0]    sync_q;
  logic          btn_s;
  logic          db;
  logic          db_q;
  logic [DW-1:0] db_cnt;
  logic          press;

  state_t        state, state_n;
  logic [SW-1:0] smp_cnt, smp_cnt_n;
  logic          pending, pending_n;
  logic [1:0]    mode_q;
  logic          mute_q;
  logic          busy_q;
  logic          mode_change_q;

  assign btn_s = sync_q[1];
  assign press = db & ~db_q;

  // Two-flop synchronizer followed by a stability counter on the synchronized level.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      sync_q <= 2'b00;
      db     <= 1'b0;
      db_q   <= 1'b0;
      db_cnt <= '0;
    end else begin
      sync_q <= {sync_q[0], bus.button};
      db_q   <= db;
      if (btn_s == db) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_LAST) begin
        db     <= btn_s;
        db_cnt <= '0;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    state_n   = state;
    smp_cnt_n = smp_cnt;
    pending_n = pending;
    case (state)
      IDLE: begin
        if (press || pending) begin
          state_n   = FADE_OUT;
          pending_n = 1'b0;
        end
      end
      FADE_OUT: begin
        if (bus.sample_strobe) begin
          if (smp_cnt == SMP_LAST) state_n = SWITCH;
          else                     smp_cnt_n = smp_cnt + 1'b1;
        end
      end
      SWITCH: state_n = FADE_IN;
      FADE_IN: begin
        if (bus.sample_strobe) begin
          if (smp_cnt == SMP_LAST) state_n = IDLE;
          else                     smp_cnt_n = smp_cnt + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
    // A press while a fade is running (including its last cycle) is held for one more pass.
    if (state != IDLE && press) pending_n = 1'b1;
    if (state_n != state) smp_cnt_n = '0;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state         <= IDLE;
      smp_cnt       <= '0;
      pending       <= 1'b0;
      mode_q        <= 2'b00;
      mute_q        <= 1'b0;
      busy_q        <= 1'b0;
      mode_change_q <= 1'b0;
    end else begin
      state         <= state_n;
      smp_cnt       <= smp_cnt_n;
      pending       <= pending_n;
      mute_q        <= (state_n != IDLE);
      busy_q        <= (state_n != IDLE);
      mode_change_q <= (state == SWITCH);
      if (state == SWITCH) mode_q <= mode_q + 2'd1;
    end
  end

  assign bus.mode        = mode_q;
  assign bus.mute        = mute_q;
  assign bus.busy        = busy_q;
  assign bus.mode_change = mode_change_q;
  assign bus.dbg_state   = state;

endmodule
